// File: rtl/neuron_serial_integrator_if.sv
// Scheduler <-> integrator start/busy/done handshake.
// master = core scheduler, slave = neuron_serial_integrator.
interface neuron_serial_integrator_if;
  logic start_i;
  logic busy_o;
  logic done_o;

  modport master (
    output start_i,
    input  busy_o,
    input  done_o
  );

  modport slave (
    input  start_i,
    output busy_o,
    output done_o
  );
endinterface

// File: rtl/neuron_serial_integrator.sv
// Multi-cycle neuron integrator: lane-serial accumulate, leak, fire.
// Define NEURON_REFRACTORY_EN to add the refractory counter ports.
module neuron_serial_integrator #(
  parameter int NUM_AXONS       = 256,
  parameter int LANES           = 8,
  parameter int NUM_WEIGHTS     = 4,
  parameter int WEIGHT_WIDTH    = 9,
  parameter int LEAK_WIDTH      = 9,
  parameter int POTENTIAL_WIDTH = 9,
  parameter int REFRAC_WIDTH    = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  neuron_serial_integrator_if.slave hs,
  input  logic [NUM_WEIGHTS*WEIGHT_WIDTH-1:0] weights_i,
  input  logic [NUM_AXONS*$clog2(NUM_WEIGHTS)-1:0] axon_types_i,
  input  logic [NUM_AXONS-1:0] synapses_in_i,
  input  logic [NUM_AXONS-1:0] axon_in_i,
  input  logic [LEAK_WIDTH-1:0] leak_i,
  input  logic [POTENTIAL_WIDTH-1:0] positive_threshold_i,
  input  logic [POTENTIAL_WIDTH-1:0] negative_threshold_i,
  input  logic [POTENTIAL_WIDTH-1:0] reset_potential_i,
  input  logic [POTENTIAL_WIDTH-1:0] current_potential_i,
  input  logic [1:0] reset_mode_i,
`ifdef NEURON_REFRACTORY_EN
  input  logic [REFRAC_WIDTH-1:0] refrac_period_i,
  input  logic [REFRAC_WIDTH-1:0] refrac_cnt_i,
  output logic [REFRAC_WIDTH-1:0] refrac_cnt_o,
`endif
  output logic [POTENTIAL_WIDTH-1:0] write_potential_o,
  output logic spike_o
);

  localparam int PW = POTENTIAL_WIDTH;
  localparam int WW = WEIGHT_WIDTH;
  localparam int IDX_W = $clog2(NUM_WEIGHTS);
  localparam int GROUPS = NUM_AXONS / LANES;
  localparam int GRP_W = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int ACC_W = PW + $clog2(NUM_AXONS) + 2;
  localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(GROUPS - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI =
    {{(ACC_W-PW+1){1'b0}}, {(PW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO =
    {{(ACC_W-PW+1){1'b1}}, {(PW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_LEAK,
    S_FIRE
  } state_t;

  function automatic logic signed [ACC_W-1:0] sx_p(
    input logic [PW-1:0] x
  );
    return {{(ACC_W-PW){x[PW-1]}}, x};
  endfunction

  function automatic logic signed [ACC_W-1:0] sx_w(
    input logic [WW-1:0] x
  );
    return {{(ACC_W-WW){x[WW-1]}}, x};
  endfunction

  function automatic logic signed [ACC_W-1:0] sx_l(
    input logic [LEAK_WIDTH-1:0] x
  );
    return {{(ACC_W-LEAK_WIDTH){x[LEAK_WIDTH-1]}}, x};
  endfunction

  function automatic logic signed [PW-1:0] sat(
    input logic signed [ACC_W-1:0] x
  );
    if (x > SAT_HI) return SAT_HI[PW-1:0];
    if (x < SAT_LO) return SAT_LO[PW-1:0];
    return x[PW-1:0];
  endfunction

  state_t state_q, state_d;

  logic [WW-1:0] w_in [NUM_WEIGHTS];
  logic [WW-1:0] wtab_q [NUM_WEIGHTS];
  logic [NUM_AXONS*IDX_W-1:0] types_q;
  logic [NUM_AXONS-1:0] act_q;
  logic [LEAK_WIDTH-1:0] leak_q;
  logic signed [PW-1:0] pthr_q, nthr_q, rpot_q;
  logic signed [PW-1:0] v_q, wpot_q;
  logic [1:0] mode_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [GRP_W-1:0] grp_q;
  logic done_q, spike_q;

  logic busy, accept;
  logic start_refrac, in_refrac;
  logic signed [ACC_W-1:0] lane_sum;
  logic signed [PW-1:0] v_next;
  logic signed [PW-1:0] fire_out;
  logic pos, neg;

  for (genvar k = 0; k < NUM_WEIGHTS; k++) begin : g_wunpack
    assign w_in[k] = weights_i[k*WW +: WW];
  end

  assign busy   = (state_q != S_IDLE) || done_q;
  assign accept = !busy && hs.start_i;

  assign hs.busy_o         = busy;
  assign hs.done_o         = done_q;
  assign write_potential_o = wpot_q;
  assign spike_o           = spike_q;

`ifdef NEURON_REFRACTORY_EN
  logic [REFRAC_WIDTH-1:0] snap_rcnt, rper_q, rcnt_out_q;

  assign start_refrac = (refrac_cnt_i != '0);
  assign in_refrac    = (snap_rcnt != '0);
  assign refrac_cnt_o = rcnt_out_q;

  // capture refractory state; publish updated count with done
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      snap_rcnt  <= '0;
      rper_q     <= '0;
      rcnt_out_q <= '0;
    end else if (accept) begin
      snap_rcnt <= refrac_cnt_i;
      rper_q    <= refrac_period_i;
    end else if (state_q == S_FIRE) begin
      if (in_refrac)
        rcnt_out_q <= snap_rcnt - REFRAC_WIDTH'(1);
      else
        rcnt_out_q <= pos ? rper_q : '0;
    end
  end
`else
  logic [REFRAC_WIDTH-1:0] snap_rcnt;

  assign snap_rcnt    = '0;
  assign start_refrac = 1'b0;
  assign in_refrac    = (snap_rcnt != '0);
`endif

  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // sequencing: refractory neurons skip synaptic input
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (accept)
          state_d = start_refrac ? S_LEAK : S_ACCUM;
      S_ACCUM:
        if (grp_q == LAST_GRP) state_d = S_LEAK;
      S_LEAK:  state_d = S_FIRE;
      S_FIRE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // gated weight sum of the current lane group
  always_comb begin
    logic [LANES-1:0] g_act;
    logic [LANES*IDX_W-1:0] g_ty;
    logic [IDX_W-1:0] ty;
    g_act = LANES'(act_q >> (grp_q * LANES));
    g_ty  = (LANES*IDX_W)'(types_q >> (grp_q * LANES * IDX_W));
    ty    = '0;
    lane_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      ty = g_ty[IDX_W-1:0];
      if (g_act[0]) lane_sum = lane_sum + sx_w(wtab_q[ty]);
      g_act = g_act >> 1;
      g_ty  = g_ty >> IDX_W;
    end
  end

  // leak then clamp to the potential range
  assign v_next = sat(acc_q + sx_l(leak_q));

  // threshold compare and reset-mode selection
  always_comb begin
    logic signed [ACC_W-1:0] dp, dn;
    dp  = sx_p(v_q) - sx_p(pthr_q);
    dn  = sx_p(v_q) - sx_p(nthr_q);
    pos = !in_refrac && (v_q >= pthr_q);
    neg = !pos && (v_q < nthr_q);
    fire_out = v_q;
    if (pos) begin
      unique case (mode_q)
        2'd1:    fire_out = sat(dp);
        2'd2:    fire_out = v_q;
        default: fire_out = rpot_q;
      endcase
    end else if (neg) begin
      unique case (mode_q)
        2'd1:    fire_out = sat(dn);
        2'd2:    fire_out = nthr_q;
        default: fire_out = rpot_q;
      endcase
    end
  end

  // snapshot, accumulate, leak and result registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wtab_q  <= '{default: '0};
      types_q <= '0;
      act_q   <= '0;
      leak_q  <= '0;
      pthr_q  <= '0;
      nthr_q  <= '0;
      rpot_q  <= '0;
      mode_q  <= '0;
      acc_q   <= '0;
      grp_q   <= '0;
      v_q     <= '0;
      wpot_q  <= '0;
      spike_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            wtab_q  <= w_in;
            types_q <= axon_types_i;
            act_q   <= synapses_in_i & axon_in_i;
            leak_q  <= leak_i;
            pthr_q  <= positive_threshold_i;
            nthr_q  <= negative_threshold_i;
            rpot_q  <= reset_potential_i;
            mode_q  <= reset_mode_i;
            acc_q   <= sx_p(current_potential_i);
            grp_q   <= '0;
          end
        end
        S_ACCUM: begin
          acc_q <= acc_q + lane_sum;
          grp_q <= grp_q + GRP_W'(1);
        end
        S_LEAK: v_q <= v_next;
        S_FIRE: begin
          wpot_q  <= fire_out;
          spike_q <= pos;
          done_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_serial_integrator.sv
// Directed and random checks of neuron_serial_integrator
// against an integer reference model.
module tb_neuron_serial_integrator;
  localparam int NA = 256;
  localparam int LN = 8;
  localparam int NW = 4;
  localparam int WW = 9;
  localparam int LW = 9;
  localparam int PW = 9;
  localparam int RW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  neuron_serial_integrator_if hs();

  logic [NW*WW-1:0] weights_v;
  logic [NA*2-1:0] types_v;
  logic [NA-1:0] syn_v, ax_v;
  logic [LW-1:0] leak_v;
  logic [PW-1:0] pthr_v, nthr_v, rpot_v, cpot_v;
  logic [1:0] mode_v;
  logic [PW-1:0] wpot;
  logic spk;
`ifdef NEURON_REFRACTORY_EN
  logic [RW-1:0] rper_v, rcnt_v, rcnt_o;
`endif

  int m_w[NW];
  int m_leak, m_pth, m_nth, m_rpot, m_pot, m_mode;
  int m_rper, m_rcnt;
  int total = 0;
  int bad = 0;

  neuron_serial_integrator dut (
    .clk_i(clk),
    .rst_i(rst),
    .hs(hs),
    .weights_i(weights_v),
    .axon_types_i(types_v),
    .synapses_in_i(syn_v),
    .axon_in_i(ax_v),
    .leak_i(leak_v),
    .positive_threshold_i(pthr_v),
    .negative_threshold_i(nthr_v),
    .reset_potential_i(rpot_v),
    .current_potential_i(cpot_v),
    .reset_mode_i(mode_v),
`ifdef NEURON_REFRACTORY_EN
    .refrac_period_i(rper_v),
    .refrac_cnt_i(rcnt_v),
    .refrac_cnt_o(rcnt_o),
`endif
    .write_potential_o(wpot),
    .spike_o(spk)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs,
                       input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  function automatic int rs(input int w);
    int r;
    r = int'($urandom_range(0, (1 << w) - 1));
    return r - (1 << (w - 1));
  endfunction

  function automatic int clamp(input int x);
    if (x > 255) return 255;
    if (x < -256) return -256;
    return x;
  endfunction

  function automatic int pot_now();
    return int'($signed(wpot));
  endfunction

  task automatic pack();
    weights_v = '0;
    for (int k = NW - 1; k >= 0; k--)
      weights_v = {weights_v[NW*WW-WW-1:0], WW'(m_w[k])};
    leak_v = LW'(m_leak);
    pthr_v = PW'(m_pth);
    nthr_v = PW'(m_nth);
    rpot_v = PW'(m_rpot);
    cpot_v = PW'(m_pot);
    mode_v = 2'(m_mode);
`ifdef NEURON_REFRACTORY_EN
    rper_v = RW'(m_rper);
    rcnt_v = RW'(m_rcnt);
`endif
  endtask

  task automatic model(output int po, output int sp,
                       output int lat, output int rc);
    logic [NA-1:0] act;
    logic [NA*2-1:0] ty;
    int acc, v;
    bit pos, neg;
    act = syn_v & ax_v;
    ty  = types_v;
    acc = m_pot;
    if (m_rcnt == 0) begin
      for (int a = 0; a < NA; a++) begin
        if (act[0]) acc += m_w[ty[1:0]];
        act = act >> 1;
        ty  = ty >> 2;
      end
    end
    acc += m_leak;
    v = clamp(acc);
    pos = (m_rcnt == 0) && (v >= m_pth);
    neg = !pos && (v < m_nth);
    po = v;
    if (pos)
      po = (m_mode == 1) ? clamp(v - m_pth) :
           (m_mode == 2) ? v : m_rpot;
    else if (neg)
      po = (m_mode == 1) ? clamp(v - m_nth) :
           (m_mode == 2) ? m_nth : m_rpot;
    sp  = pos ? 1 : 0;
    lat = (m_rcnt != 0) ? 2 : NA / LN + 2;
    rc  = (m_rcnt != 0) ? m_rcnt - 1 : (pos ? m_rper : 0);
  endtask

  task automatic scramble();
    for (int i = 0; i < NA / 32; i++) begin
      syn_v = {syn_v[NA-33:0], $urandom()};
      ax_v  = {ax_v[NA-33:0], $urandom()};
    end
    for (int i = 0; i < NA / 16; i++)
      types_v = {types_v[NA*2-33:0], $urandom()};
    weights_v = (NW*WW)'({$urandom(), $urandom()});
    leak_v = LW'($urandom());
    pthr_v = PW'($urandom());
    nthr_v = PW'($urandom());
    rpot_v = PW'($urandom());
    cpot_v = PW'($urandom());
    mode_v = 2'($urandom());
`ifdef NEURON_REFRACTORY_EN
    rper_v = RW'($urandom());
    rcnt_v = RW'($urandom());
`endif
  endtask

  task automatic run(input string tag, input bit hold);
    int ep, es, el, erc, cyc;
    pack();
    model(ep, es, el, erc);
    @(negedge clk);
    check({tag, "_idle_busy"}, int'(hs.busy_o), 0);
    hs.start_i = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) hs.start_i = 1'b0;
    scramble();
    check({tag, "_busy"}, int'(hs.busy_o), 1);
    cyc = 0;
    while (hs.done_o !== 1'b1 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_latency"}, cyc, el);
    check({tag, "_pot"}, pot_now(), ep);
    check({tag, "_spike"}, int'(spk), es);
    check({tag, "_busy_done"}, int'(hs.busy_o), 1);
`ifdef NEURON_REFRACTORY_EN
    check({tag, "_rcnt"}, int'(rcnt_o), erc);
`endif
    @(posedge clk);
    #1;
    hs.start_i = 1'b0;
    check({tag, "_done_pulse"}, int'(hs.done_o), 0);
    check({tag, "_busy_after"}, int'(hs.busy_o), 0);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_no_queue"}, int'(hs.busy_o), 0);
    check({tag, "_hold"}, pot_now(), ep);
  endtask

  task automatic set_defaults();
    m_w[0] = 1;
    m_w[1] = -1;
    m_w[2] = 2;
    m_w[3] = -2;
    types_v = '0;
    for (int a = NA - 1; a >= 0; a--)
      types_v = {types_v[NA*2-3:0], 2'(a % 4)};
    syn_v  = '1;
    ax_v   = '1;
    m_pot  = 0;
    m_leak = 0;
    m_pth  = 100;
    m_nth  = -100;
    m_rpot = 0;
    m_mode = 0;
    m_rper = 0;
    m_rcnt = 0;
  endtask

  initial begin
    int dn;
    hs.start_i = 1'b0;
    set_defaults();
    pack();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(hs.busy_o), 0);
    check("rst_done", int'(hs.done_o), 0);
    check("rst_pot", pot_now(), 0);
    check("rst_spike", int'(spk), 0);
    @(negedge clk);
    rst = 1'b0;

    set_defaults();
    run("t1_zero", 1'b0);
    check("t1_pot_c", pot_now(), 0);
    check("t1_spk_c", int'(spk), 0);

    set_defaults();
    types_v = {NA{2'b10}};
    m_rpot = -5;
    run("t2_sat", 1'b0);
    check("t2_pot_c", pot_now(), -5);
    check("t2_spk_c", int'(spk), 1);

    set_defaults();
    m_w[0] = 20;
    types_v = '0;
    ax_v = '0;
    ax_v[0] = 1'b1;
    m_pot = 90;
    m_mode = 1;
    run("t3_lin", 1'b1);
    check("t3_pot_c", pot_now(), 10);
    check("t3_spk_c", int'(spk), 1);

    set_defaults();
    ax_v = '0;
    m_pot = -95;
    m_leak = -10;
    m_mode = 2;
    run("t4_neg", 1'b0);
    check("t4_pot_c", pot_now(), -100);
    check("t4_spk_c", int'(spk), 0);

    set_defaults();
    types_v = {NA{2'b10}};
    m_rpot = -5;
    run("t5_prev", 1'b0);
    pack();
    @(negedge clk);
    hs.start_i = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    hs.start_i = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", int'(hs.busy_o), 0);
    check("abort_pot", pot_now(), 0);
    check("abort_spike", int'(spk), 0);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (hs.done_o === 1'b1) dn++;
    end
    check("abort_no_done", dn, 0);

`ifdef NEURON_REFRACTORY_EN
    set_defaults();
    types_v = {NA{2'b10}};
    m_rcnt = 3;
    m_rper = 7;
    run("r1_refrac", 1'b0);
    check("r1_spk_c", int'(spk), 0);
    check("r1_cnt_c", int'(rcnt_o), 2);

    set_defaults();
    types_v = {NA{2'b10}};
    m_rper = 5;
    run("r2_period", 1'b0);
    check("r2_cnt_c", int'(rcnt_o), 5);
`endif

    for (int t = 0; t < 20; t++) begin
      int ww;
      ww = (t % 2 == 0) ? 4 : WW;
      for (int k = 0; k < NW; k++) m_w[k] = rs(ww);
      for (int i = 0; i < NA / 32; i++) begin
        syn_v = {syn_v[NA-33:0], $urandom()};
        ax_v  = {ax_v[NA-33:0], $urandom() & $urandom()};
      end
      for (int i = 0; i < NA / 16; i++)
        types_v = {types_v[NA*2-33:0], $urandom()};
      m_pot  = rs(PW);
      m_leak = rs(LW);
      m_pth  = rs(PW);
      m_nth  = rs(PW);
      m_rpot = rs(PW);
      m_mode = int'($urandom_range(0, 3));
      m_rper = int'($urandom_range(0, (1 << RW) - 1));
`ifdef NEURON_REFRACTORY_EN
      m_rcnt = (t % 3 == 0) ?
               int'($urandom_range(1, (1 << RW) - 1)) : 0;
`else
      m_rcnt = 0;
`endif
      run($sformatf("rnd%0d", t), t % 4 == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
